bp_update_ctrl: RTL and testbench

- Sequencer for the branch history table's single write port; sits between the EX stage and the table.
- Detects mispredicts and drives flush/redirect, and queues branch resolutions from EX.
- Drains the queue with a read-modify-write of the 2-bit counter.
- After reset or on a clear request, runs a sweep that invalidates every entry one per cycle, so the table needs no single-cycle reset loop.

---
 rtl/bp_pkg.sv | 43 ++++
 rtl/bp_upd_fifo.sv | 55 +++++
 rtl/bp_update_ctrl.sv | 128 ++++++++++++
 tb/tb_bp_update_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch history table update sequencer.
package bp_pkg;

    // Sequencer states
    localparam logic [0:0] StInit = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    // 2-bit direction counter encodings
    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    // Default table geometry (1024 entries, 30-bit word PC)
    localparam int unsigned DEF_INDEX = 10;
    localparam int unsigned DEF_TAG   = 30 - DEF_INDEX;

    // Table entry at default geometry; non-default instances build the same layout locally
    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG-1:0]   tag;
        logic [1:0]           ctr;
    } bp_entry_t;

    // Queued branch resolution
    typedef struct packed {
        logic [29:0] pc;
        logic        taken;
    } bp_upd_t;

    // Saturating 2-bit counter step towards the resolved direction
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        unique case (ctr)
            STRONG_NT: res = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   res = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    res = taken ? STRONG_T : WEAK_NT;
            default:   res = taken ? STRONG_T : WEAK_T;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small power-of-two FIFO for pending branch resolutions.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module bp_upd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 31
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_en = push_i & (~full_o | pop_i);
    assign pop_en  = pop_i & ~empty_o;
    assign rdata_o = mem[rd_ptr_q];

    // Pointer and occupancy tracking; clear discards everything including a same-cycle push
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_en && !pop_en)      count_q <= count_q + 1'b1;
            else if (pop_en && !push_en) count_q <= count_q - 1'b1;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_en && !clr_i) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch history table write-port sequencer: mispredict flush/redirect, update queue,
// counter read-modify-write and a one-entry-per-cycle invalidation sweep.
// Optional statistics counters are built when BP_STATS_EN is defined.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned  SIZE   = 1024,
    parameter int unsigned  QDEPTH = 4,
    localparam int unsigned INDEX  = $clog2(SIZE),
    localparam int unsigned TAG    = 30 - INDEX
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             branch_ex,
    input  logic             taken_ex,
    input  logic             pred_ex,
    input  logic [29:0]      pc_ex,
    input  logic [29:0]      target_ex,
    input  logic             clear_req,
    output logic             flush,
    output logic [29:0]      redirect_pc,
    output logic             busy,
    output logic [INDEX-1:0] tbl_rd_idx,
    input  logic [1:0]       tbl_rd_ctr,
    output logic             tbl_we,
    output logic [INDEX-1:0] tbl_wr_idx,
    output logic [TAG+2:0]   tbl_wr_data
`ifdef BP_STATS_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispred,
    output logic [31:0]      stat_dropped
`endif
);

    logic [0:0]       state_q, state_d;
    logic [INDEX-1:0] sweep_idx_q, sweep_idx_d;
    logic             in_init;
    logic             q_full, q_empty, q_pop;
    bp_upd_t          q_head;

    assign in_init     = (state_q == StInit);
    assign busy        = in_init;
    assign flush       = branch_ex & (taken_ex ^ pred_ex);
    assign redirect_pc = flush ? (taken_ex ? target_ex : pc_ex + 30'd1) : '0;
    // Sweep owns the write port; a clear cycle issues no update so nothing lands before the sweep
    assign q_pop       = ~in_init & ~q_empty & ~clear_req;

    bp_upd_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(bp_upd_t))
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (clear_req),
        .push_i  (branch_ex),
        .pop_i   (q_pop),
        .wdata_i ({pc_ex, taken_ex}),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Next-state: clear restarts the sweep from either state; sweep index wraps at SIZE
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        if (clear_req) begin
            state_d     = StInit;
            sweep_idx_d = '0;
        end else if (in_init) begin
            sweep_idx_d = sweep_idx_q + 1'b1;
            if (sweep_idx_q == INDEX'(SIZE - 1)) state_d = StRun;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StInit;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // Table port drive; held quiet while reset is asserted
    always_comb begin
        tbl_rd_idx  = '0;
        tbl_we      = 1'b0;
        tbl_wr_idx  = '0;
        tbl_wr_data = '0;
        if (rstn) begin
            if (in_init) begin
                tbl_we      = 1'b1;
                tbl_wr_idx  = sweep_idx_q;
                tbl_wr_data = {1'b0, {TAG{1'b0}}, WEAK_NT};
            end else if (q_pop) begin
                tbl_rd_idx  = q_head.pc[INDEX-1:0];
                tbl_we      = 1'b1;
                tbl_wr_idx  = q_head.pc[INDEX-1:0];
                tbl_wr_data = {1'b1, q_head.pc[29:INDEX], sat_update(tbl_rd_ctr, q_head.taken)};
            end
        end
    end

`ifdef BP_STATS_EN
    logic dropped;

    // Push lost to a full queue; a clear-cycle push is discarded, not dropped
    assign dropped = branch_ex & q_full & ~q_pop & ~clear_req;

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
            stat_dropped  <= '0;
        end else begin
            if (branch_ex && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
            if (flush && stat_mispred != '1)      stat_mispred  <= stat_mispred + 32'd1;
            if (dropped && stat_dropped != '1)    stat_dropped  <= stat_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl with a behavioural counter table on the table port.
module tb_bp_update_ctrl;

    localparam int unsigned SIZE  = 1024;
    localparam int unsigned INDEX = 10;
    localparam int unsigned TAG   = 20;

    logic             clk = 1'b0;
    logic             rstn;
    logic             branch_ex, taken_ex, pred_ex, clear_req;
    logic [29:0]      pc_ex, target_ex;
    logic             flush, busy, tbl_we;
    logic [29:0]      redirect_pc;
    logic [INDEX-1:0] tbl_rd_idx, tbl_wr_idx;
    logic [1:0]       tbl_rd_ctr;
    logic [TAG+2:0]   tbl_wr_data;
`ifdef BP_STATS_EN
    logic [31:0]      stat_branches, stat_mispred, stat_dropped;
`endif

    int n_err = 0;
    int n_chk = 0;

    bp_update_ctrl #(
        .SIZE   (SIZE),
        .QDEPTH (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .branch_ex   (branch_ex),
        .taken_ex    (taken_ex),
        .pred_ex     (pred_ex),
        .pc_ex       (pc_ex),
        .target_ex   (target_ex),
        .clear_req   (clear_req),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .busy        (busy),
        .tbl_rd_idx  (tbl_rd_idx),
        .tbl_rd_ctr  (tbl_rd_ctr),
        .tbl_we      (tbl_we),
        .tbl_wr_idx  (tbl_wr_idx),
        .tbl_wr_data (tbl_wr_data)
`ifdef BP_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred),
        .stat_dropped  (stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    // Counter table: combinational read, write on rising edge
    logic [1:0] tctr [SIZE];
    always @(posedge clk) if (tbl_we) tctr[tbl_wr_idx] <= tbl_wr_data[1:0];
    assign tbl_rd_ctr = tctr[tbl_rd_idx];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic b, input logic t, input logic p,
                      input logic [29:0] pc, input logic [29:0] tgt);
        branch_ex = b;
        taken_ex  = t;
        pred_ex   = p;
        pc_ex     = pc;
        target_ex = tgt;
    endtask

    // Full invalidation sweep, optionally pushing taken branches on its first cycles
    task automatic sweep(input int npush, input logic [29:0] base);
        for (int i = 0; i < int'(SIZE); i++) begin
            if (i < npush) br(1'b1, 1'b1, 1'b1, base + 30'(i), 30'h0);
            else           br(1'b0, 1'b0, 1'b0, 30'h0, 30'h0);
            #1;
            chk("sweep", {busy, tbl_we, tbl_wr_idx, tbl_wr_data},
                {2'b11, 10'(i), 1'b0, 20'h0, 2'b01});
            tick();
        end
        br(1'b0, 1'b0, 1'b0, 30'h0, 30'h0);
    endtask

    logic [1:0] exp_d [4];

    initial begin
        rstn      = 1'b0;
        clear_req = 1'b0;
        br(1'b0, 1'b0, 1'b0, 30'h0, 30'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  busy, 1);
        chk("rst_we",    tbl_we, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redir", redirect_pc, 0);
        chk("rst_wdata", tbl_wr_data, 0);
        rstn = 1'b1;

        // Sweep after reset release
        sweep(0, 30'h0);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_we",   tbl_we, 0);
        tick();

        // Taken mispredict, then the counter write 01 -> 10
        br(1'b1, 1'b1, 1'b0, 30'h100, 30'h200);
        #1;
        chk("mp_flush", flush, 1);
        chk("mp_redir", redirect_pc, 30'h200);
        tick();
        br(1'b0, 1'b0, 1'b0, 30'h0, 30'h0);
        #1;
        chk("mp_we",    tbl_we, 1);
        chk("mp_rdidx", tbl_rd_idx, 10'h100);
        chk("mp_wridx", tbl_wr_idx, 10'h100);
        chk("mp_wdata", tbl_wr_data, {1'b1, 20'h0, 2'b10});
        tick();

        // Correctly predicted taken stream to idx 0x44, tag 3: 01->10 then saturates at 11
        exp_d = '{2'b10, 2'b11, 2'b11, 2'b11};
        for (int k = 0; k < 5; k++) begin
            if (k < 4) br(1'b1, 1'b1, 1'b1, 30'hC44, 30'h3AB);
            else       br(1'b0, 1'b0, 1'b0, 30'h0, 30'h0);
            #1;
            if (k < 4) begin
                chk("sat_flush", flush, 0);
                chk("sat_redir", redirect_pc, 0);
            end
            if (k > 0) begin
                chk("sat_idx",   {tbl_we, tbl_wr_idx}, {1'b1, 10'h44});
                chk("sat_wdata", tbl_wr_data, {1'b1, 20'h3, exp_d[k-1]});
            end
            tick();
        end

        // Not-taken pair to idx 0x55: 01->00 then stays 00
        for (int k = 0; k < 3; k++) begin
            if (k < 2) br(1'b1, 1'b0, 1'b0, 30'h55, 30'h0);
            else       br(1'b0, 1'b0, 1'b0, 30'h0, 30'h0);
            #1;
            if (k > 0) chk("nt_wdata", {tbl_we, tbl_wr_idx, tbl_wr_data},
                           {1'b1, 10'h55, 1'b1, 20'h0, 2'b00});
            tick();
        end

        // Not-taken mispredict at the top of the PC space: fall-through wraps to 0
        br(1'b1, 1'b0, 1'b1, 30'h3FFFFFFF, 30'h123);
        #1;
        chk("wrap_flush", flush, 1);
        chk("wrap_redir", redirect_pc, 30'h0);
        tick();
        br(1'b0, 1'b0, 1'b0, 30'h0, 30'h0);
        #1;
        chk("wrap_wr", {tbl_we, tbl_wr_idx, tbl_wr_data}, {1'b1, 10'h3FF, 1'b1, 20'hFFFFF, 2'b00});
        tick();

        // Clear from RUN; six branches during the sweep: four kept, two dropped
        clear_req = 1'b1;
        #1;
        chk("clr_we", tbl_we, 0);
        tick();
        clear_req = 1'b0;
        sweep(6, 30'h200);
        for (int j = 0; j < 5; j++) begin
            #1;
            if (j < 4) chk("drain", {tbl_we, tbl_wr_idx, tbl_wr_data},
                           {1'b1, 10'(32'h200 + j), 1'b1, 20'h0, 2'b10});
            else       chk("drain_end", {busy, tbl_we}, 2'b00);
            tick();
        end
`ifdef BP_STATS_EN
        chk("stat_dropped", stat_dropped, 2);
`endif

        // Clear with three entries still queued in RUN: queue discarded, sweep restarts
        clear_req = 1'b1;
        #1;
        tick();
        clear_req = 1'b0;
        sweep(4, 30'h300);
        #1;
        chk("q3_first", {tbl_we, tbl_wr_idx}, {1'b1, 10'h300});
        tick();
        clear_req = 1'b1;
        #1;
        chk("q3_clr_we",   tbl_we, 0);
        chk("q3_clr_busy", busy, 0);
        tick();
        clear_req = 1'b0;
        sweep(0, 30'h0);
        #1;
        chk("q3_discard", {busy, tbl_we}, 2'b00);
        tick();

`ifdef BP_STATS_EN
        chk("stat_branches", stat_branches, 18);
        chk("stat_mispred",  stat_mispred, 2);
        chk("stat_dropped2", stat_dropped, 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
